vga_timing: RTL and testbench

//   Raster timing generator for 640x480@60Hz VGA (25.175 MHz pixel clock).

---
 rtl/vga_timing.sv | 79 +++++++
 tb/tb_vga_timing.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// Raster timing generator for 640x480@60Hz VGA: free-running pixel/line
// counters with registered negative syncs, display enable and frame strobe.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_q, frame_d;
  logic       line_end;

  // Syncs and the frame strobe are decoded from the current counters and
  // registered, so they appear one pixel clock after the counter value.
  always_comb begin
    line_end = (hcnt_q == H_LAST);
    hcnt_d   = line_end ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d   = vcnt_q;
    if (line_end) begin
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
    hsync_d = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
    vsync_d = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
    frame_d = line_end && (vcnt_q == V_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_q <= frame_d;
    end
  end

  assign hcount      = hcnt_q;
  assign vcount      = vcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_q;
  assign display_en  = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);

endmodule

// File: tb/tb_vga_timing.sv
// Directed checks of vga_timing: full-size instance for line timing and
// mid-line reset, and a shrunken-geometry instance for vertical/frame timing.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, resetS;
  logic [9:0] hcount, vcount, hcountS, vcountS;
  logic       hsync, vsync, displayEn, frameStart;
  logic       hsyncS, vsyncS, displayEnS, frameStartS;

  int checks   = 0;
  int failures = 0;

  vga_timing dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .display_en(displayEn), .frame_start(frameStart)
  );

  // Small geometry: line 16 clks (sync low for hcount 10..12), frame 12 lines
  // (sync low for vcount 8..9), so a whole frame is 192 clks.
  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dutS (
    .clk(clk), .reset(resetS), .hcount(hcountS), .vcount(vcountS),
    .hsync(hsyncS), .vsync(vsyncS), .display_en(displayEnS), .frame_start(frameStartS)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input int cycles);
    reset = rst;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitDut(input int h, input int v, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (hcount == 10'(h) && vcount == 10'(v)) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(hit), 32'd1);
  endtask

  task automatic waitSmall(input int h, input int v, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (hcountS == 10'(h) && vcountS == 10'(v)) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int lowCnt, fsCnt, deCnt, deLate, vsLow, frameLen;
    bit seen;
    resetS = 1'b1;
    applyStimulus(1'b1, 10);
    checkOutput("rst_hcount", 32'(hcount), 32'd0);
    checkOutput("rst_vcount", 32'(vcount), 32'd0);
    checkOutput("rst_hsync", 32'(hsync), 32'd1);
    checkOutput("rst_vsync", 32'(vsync), 32'd1);
    checkOutput("rst_frame", 32'(frameStart), 32'd0);
    checkOutput("rst_frameS", 32'(frameStartS), 32'd0);

    reset = 1'b0;
    #1;
    checkOutput("rel_hcount", 32'(hcount), 32'd0);
    checkOutput("rel_de", 32'(displayEn), 32'd1);
    @(negedge clk);
    checkOutput("first_hcount", 32'(hcount), 32'd1);
    checkOutput("first_vcount", 32'(vcount), 32'd0);
    checkOutput("first_hsync", 32'(hsync), 32'd1);
    checkOutput("first_vsync", 32'(vsync), 32'd1);
    checkOutput("first_frame", 32'(frameStart), 32'd0);

    // Visible edge and horizontal sync placement on line 0.
    waitDut(639, 0, "reach_639");
    checkOutput("de_639", 32'(displayEn), 32'd1);
    checkOutput("hs_639", 32'(hsync), 32'd1);
    @(negedge clk);
    checkOutput("de_640", 32'(displayEn), 32'd0);
    checkOutput("hs_640", 32'(hsync), 32'd1);
    waitDut(655, 0, "reach_655");
    checkOutput("de_655", 32'(displayEn), 32'd0);
    checkOutput("hs_655", 32'(hsync), 32'd1);
    @(negedge clk);
    checkOutput("hs_656", 32'(hsync), 32'd1);
    @(negedge clk);
    checkOutput("hs_after_656", 32'(hsync), 32'd0);
    waitDut(752, 0, "reach_752");
    checkOutput("hs_after_751", 32'(hsync), 32'd0);
    @(negedge clk);
    checkOutput("hs_after_752", 32'(hsync), 32'd1);

    waitDut(799, 0, "reach_799");
    @(negedge clk);
    checkOutput("wrap_hcount", 32'(hcount), 32'd0);
    checkOutput("wrap_vcount", 32'(vcount), 32'd1);
    checkOutput("wrap_de", 32'(displayEn), 32'd1);
    checkOutput("wrap_frame", 32'(frameStart), 32'd0);

    // Sweep line 1 to measure the hsync low width.
    lowCnt = 0;
    fsCnt  = 0;
    for (int i = 0; i < 800; i++) begin
      if (hsync === 1'b0) lowCnt++;
      if (frameStart === 1'b1) fsCnt++;
      @(negedge clk);
    end
    checkOutput("hs_low_width", 32'(lowCnt), 32'd96);
    checkOutput("no_early_frame", 32'(fsCnt), 32'd0);
    checkOutput("line2_hcount", 32'(hcount), 32'd0);
    checkOutput("line2_vcount", 32'(vcount), 32'd2);

    // Reset asserted mid-line while hsync is low takes effect without a clock.
    waitDut(700, 2, "reach_700");
    checkOutput("mid_hs_low", 32'(hsync), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_hcount", 32'(hcount), 32'd0);
    checkOutput("mid_rst_vcount", 32'(vcount), 32'd0);
    checkOutput("mid_rst_hsync", 32'(hsync), 32'd1);
    checkOutput("mid_rst_vsync", 32'(vsync), 32'd1);
    checkOutput("mid_rst_frame", 32'(frameStart), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("restart_hcount", 32'(hcount), 32'd1);
    checkOutput("restart_vcount", 32'(vcount), 32'd0);
    checkOutput("restart_hsync", 32'(hsync), 32'd1);

    // Small instance: first frame strobe one full frame after release.
    resetS = 1'b0;
    frameLen = 0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      frameLen++;
      if (frameStartS === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("s_first_frame_seen", 32'(seen), 32'd1);
    checkOutput("s_frame_period", 32'(frameLen), 32'd192);
    checkOutput("s_frame_hcount", 32'(hcountS), 32'd0);
    checkOutput("s_frame_vcount", 32'(vcountS), 32'd0);
    @(negedge clk);
    checkOutput("s_frame_width", 32'(frameStartS), 32'd0);
    checkOutput("s_after_frame_h", 32'(hcountS), 32'd1);

    // One full frame sweep: visible area, vsync width, strobe count.
    deCnt = 0;
    deLate = 0;
    vsLow = 0;
    fsCnt = 0;
    for (int i = 0; i < 192; i++) begin
      if (displayEnS === 1'b1) deCnt++;
      if (displayEnS === 1'b1 && vcountS >= 10'd6) deLate++;
      if (vsyncS === 1'b0) vsLow++;
      if (frameStartS === 1'b1) fsCnt++;
      @(negedge clk);
    end
    checkOutput("s_de_count", 32'(deCnt), 32'd48);
    checkOutput("s_de_late_lines", 32'(deLate), 32'd0);
    checkOutput("s_vs_low_width", 32'(vsLow), 32'd32);
    checkOutput("s_frame_count", 32'(fsCnt), 32'd1);

    // Vertical sync edges and line wrap.
    waitSmall(15, 7, "s_reach_15_7");
    checkOutput("s_vs_line7", 32'(vsyncS), 32'd1);
    @(negedge clk);
    checkOutput("s_wrap_h", 32'(hcountS), 32'd0);
    checkOutput("s_wrap_v", 32'(vcountS), 32'd8);
    checkOutput("s_vs_0_8", 32'(vsyncS), 32'd1);
    @(negedge clk);
    checkOutput("s_vs_after_0_8", 32'(vsyncS), 32'd0);
    waitSmall(0, 10, "s_reach_0_10");
    checkOutput("s_vs_0_10", 32'(vsyncS), 32'd0);
    @(negedge clk);
    checkOutput("s_vs_after_0_10", 32'(vsyncS), 32'd1);

    // Frame wrap (15,11) -> (0,0) with a one-clock strobe.
    waitSmall(15, 11, "s_reach_15_11");
    checkOutput("s_de_last", 32'(displayEnS), 32'd0);
    checkOutput("s_fs_before", 32'(frameStartS), 32'd0);
    @(negedge clk);
    checkOutput("s_fwrap_h", 32'(hcountS), 32'd0);
    checkOutput("s_fwrap_v", 32'(vcountS), 32'd0);
    checkOutput("s_fwrap_fs", 32'(frameStartS), 32'd1);
    @(negedge clk);
    checkOutput("s_fwrap_fs_off", 32'(frameStartS), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
